// File: rtl/stack_fetch_port.sv
// stack_fetch_port: fetch/issue front end for a simple stack CPU.
// Each instruction is accepted in WAIT, offered to execute in ISSUE and
// retired in EXEC. The PC either steps by one or takes a branch target.
// Opcodes above MAX_OP retire straight from WAIT, raise a sticky flag and
// are never offered to execute.
module stack_fetch_port #(
    parameter int                         CPU_BIT_WIDTH = 32,
    parameter int                         MAX_OP        = 16,
    parameter logic [CPU_BIT_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CPU_BIT_WIDTH-1:0]      inst,
    input  logic                          inst_ready,
    output logic                          inst_complete,
    output logic [CPU_BIT_WIDTH-1:0]      pc_next,
    output logic                          ex_valid,
    output logic [4:0]                    ex_opcode,
    output logic [CPU_BIT_WIDTH-6:0]      ex_operand,
    input  logic                          ex_ready,
    input  logic                          ex_done,
    input  logic                          ex_branch,
    input  logic [CPU_BIT_WIDTH-1:0]      ex_target,
    output logic                          illegal,
    output logic [CPU_BIT_WIDTH-1:0]      retired
);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [CPU_BIT_WIDTH-1:0] ONE = CPU_BIT_WIDTH'(1);

    state_t state;
    logic   op_illegal;

    // Opcode legality of the word currently presented by the supplier
    always_comb begin
        op_illegal = int'(inst[CPU_BIT_WIDTH-1 -: 5]) > MAX_OP;
    end

    // Control FSM with registered handshake outputs, PC and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WAIT;
            pc_next       <= RESET_PC;
            inst_complete <= 1'b1;
            ex_valid      <= 1'b0;
            ex_opcode     <= '0;
            ex_operand    <= '0;
            illegal       <= 1'b0;
            retired       <= '0;
        end else begin
            case (state)
                WAIT: begin
                    if (inst_ready) begin
                        if (op_illegal) begin
                            // Retire in place: the bad word never reaches execute
                            illegal <= 1'b1;
                            pc_next <= pc_next + ONE;
                            retired <= retired + ONE;
                        end else begin
                            ex_opcode     <= inst[CPU_BIT_WIDTH-1 -: 5];
                            ex_operand    <= inst[CPU_BIT_WIDTH-6:0];
                            ex_valid      <= 1'b1;
                            inst_complete <= 1'b0;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // ex_done is deliberately not looked at here, even
                    // alongside ex_ready: completion only counts in EXEC
                    if (ex_ready) begin
                        ex_valid <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (ex_done) begin
                        pc_next       <= ex_branch ? ex_target : pc_next + ONE;
                        retired       <= retired + ONE;
                        inst_complete <= 1'b1;
                        state         <= WAIT;
                    end
                end
                default: begin
                    ex_valid      <= 1'b0;
                    inst_complete <= 1'b1;
                    state         <= WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_fetch_port.sv
// Testbench for stack_fetch_port: directed scenarios followed by random
// traffic, compared every cycle against a transaction-level model.
module tb_stack_fetch_port;

    localparam int MAX_OP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = '0;
    logic        inst_ready = 1'b0;
    logic        ex_ready = 1'b0;
    logic        ex_done = 1'b0;
    logic        ex_branch = 1'b0;
    logic [31:0] ex_target = '0;

    logic        inst_complete, ex_valid, illegal;
    logic [31:0] pc_next, retired;
    logic [4:0]  ex_opcode;
    logic [26:0] ex_operand;

    logic        inst_complete_b, ex_valid_b, illegal_b;
    logic [31:0] pc_next_b, retired_b;
    logic [4:0]  ex_opcode_b;
    logic [26:0] ex_operand_b;

    int checks = 0;
    int errors = 0;

    // Model: which step of its life the current instruction is in
    // (0 = waiting for a word, 1 = offered, 2 = executing)
    int          m_phase;
    logic [31:0] m_held;
    logic [31:0] m_pc, m_pc_b, m_retired;
    logic        m_illegal;

    always #5 clk = ~clk;

    stack_fetch_port #(.CPU_BIT_WIDTH(32), .MAX_OP(MAX_OP), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_ready(inst_ready),
        .inst_complete(inst_complete), .pc_next(pc_next), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_operand(ex_operand), .ex_ready(ex_ready),
        .ex_done(ex_done), .ex_branch(ex_branch), .ex_target(ex_target),
        .illegal(illegal), .retired(retired)
    );

    stack_fetch_port #(.CPU_BIT_WIDTH(32), .MAX_OP(MAX_OP), .RESET_PC(32'hFFFF_FFFF)) dut_b (
        .clk(clk), .rst(rst), .inst(inst), .inst_ready(inst_ready),
        .inst_complete(inst_complete_b), .pc_next(pc_next_b), .ex_valid(ex_valid_b),
        .ex_opcode(ex_opcode_b), .ex_operand(ex_operand_b), .ex_ready(ex_ready),
        .ex_done(ex_done), .ex_branch(ex_branch), .ex_target(ex_target),
        .illegal(illegal_b), .retired(retired_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs seen at the edge
    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_held = '0; m_pc = 32'h0; m_pc_b = 32'hFFFF_FFFF;
            m_retired = '0; m_illegal = 1'b0;
        end else if (m_phase == 0 && inst_ready) begin
            if (int'(inst >> 27) > MAX_OP) begin
                m_illegal = 1'b1;
                m_pc = m_pc + 1; m_pc_b = m_pc_b + 1;
                m_retired = m_retired + 1;
            end else begin
                m_held = inst;
                m_phase = 1;
            end
        end else if (m_phase == 1 && ex_ready) begin
            m_phase = 2;
        end else if (m_phase == 2 && ex_done) begin
            m_pc   = ex_branch ? ex_target : m_pc + 1;
            m_pc_b = ex_branch ? ex_target : m_pc_b + 1;
            m_retired = m_retired + 1;
            m_phase = 0;
        end
    endtask

    task automatic compare_all();
        chk("inst_complete", 32'(inst_complete), 32'(m_phase == 0));
        chk("ex_valid",      32'(ex_valid),      32'(m_phase == 1));
        chk("ex_opcode",     32'(ex_opcode),     m_held >> 27);
        chk("ex_operand",    32'(ex_operand),    m_held & 32'h07FF_FFFF);
        chk("pc_next",       pc_next,            m_pc);
        chk("illegal",       32'(illegal),       32'(m_illegal));
        chk("retired",       retired,            m_retired);
        chk("pc_next_b",     pc_next_b,          m_pc_b);
        chk("ex_valid_b",    32'(ex_valid_b),    32'(m_phase == 1));
        chk("retired_b",     retired_b,          m_retired);
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cycle(); cycle();
        chk("rst_pc", pc_next, 32'h0);
        chk("rst_pc_b", pc_next_b, 32'hFFFF_FFFF);
        chk("rst_complete", 32'(inst_complete), 32'h1);
        rst = 1'b0;
        cycle();

        // Basic instruction: issue latency one cycle, then retire
        inst = 32'h0800_001A; inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        chk("basic_valid", 32'(ex_valid), 32'h1);
        chk("basic_opcode", 32'(ex_opcode), 32'h1);
        chk("basic_operand", 32'(ex_operand), 32'h1A);
        chk("basic_complete", 32'(inst_complete), 32'h0);
        ex_ready = 1'b1;
        cycle();
        ex_ready = 1'b0; ex_done = 1'b1; ex_branch = 1'b0;
        cycle();
        ex_done = 1'b0;
        chk("basic_pc", pc_next, 32'h1);
        chk("basic_retired", retired, 32'h1);
        chk("basic_complete2", 32'(inst_complete), 32'h1);
        chk("wrap_pc_b", pc_next_b, 32'h0);

        // ex_done alongside ex_ready in ISSUE is ignored; inst_ready ignored in EXEC
        inst = 32'h1000_0005; inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0; ex_ready = 1'b1; ex_done = 1'b1;
        cycle();
        ex_ready = 1'b0; ex_done = 1'b0;
        chk("same_cycle_valid", 32'(ex_valid), 32'h0);
        chk("same_cycle_complete", 32'(inst_complete), 32'h0);
        chk("same_cycle_retired", retired, 32'h1);
        inst = 32'h2000_0999; inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        chk("hold_opcode", 32'(ex_opcode), 32'h2);
        chk("hold_operand", 32'(ex_operand), 32'h5);
        ex_done = 1'b1; ex_branch = 1'b1; ex_target = 32'h7;
        cycle();
        ex_done = 1'b0; ex_branch = 1'b0;
        chk("branch_pc", pc_next, 32'h7);

        // Illegal opcode retires in WAIT
        inst = 32'hF800_0000; inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        chk("illegal_flag", 32'(illegal), 32'h1);
        chk("illegal_valid", 32'(ex_valid), 32'h0);
        chk("illegal_pc", pc_next, 32'h8);
        chk("illegal_complete", 32'(inst_complete), 32'h1);
        cycle();
        chk("illegal_sticky", 32'(illegal), 32'h1);

        // Reset from EXEC
        inst = 32'h0300_0011; inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0; ex_ready = 1'b1;
        cycle();
        ex_ready = 1'b0; rst = 1'b1; ex_done = 1'b1; inst_ready = 1'b1;
        cycle();
        rst = 1'b0; ex_done = 1'b0; inst_ready = 1'b0;
        chk("exec_rst_pc", pc_next, 32'h0);
        chk("exec_rst_opcode", 32'(ex_opcode), 32'h0);
        chk("exec_rst_illegal", 32'(illegal), 32'h0);
        chk("exec_rst_retired", retired, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            inst_ready = ($urandom_range(0, 2) == 0);
            inst       = {5'($urandom_range(0, 31)), 27'($urandom)};
            ex_ready   = ($urandom_range(0, 2) == 0);
            ex_done    = ($urandom_range(0, 2) == 0);
            ex_branch  = $urandom_range(0, 1) == 1;
            ex_target  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
